// File: rtl/tx_ppdu_framer.sv
`default_nettype none
// ============================================================================
// Module  : tx_ppdu_framer
// Purpose : Serialises SERVICE, PSDU (LSB first), tail and pad bits into the
//           802.11a TX chain and issues the rate-latching tx_request pulse.
// Rev     : 1.0
// ============================================================================
module tx_ppdu_framer #(
  parameter int LEN_W = 12,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       rate_in,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             scr_ready,
  output logic             bit_out,
  output logic             bit_run,
  output logic             bit_tail,
  output logic             tx_request,
  output logic [3:0]       rate_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_SERVICE = 3'd2,
    S_DATA    = 3'd3,
    S_TAIL    = 3'd4,
    S_PAD     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         rate_q, rate_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [LEN_W+2:0]   data_cnt_q, data_cnt_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         sh_q, sh_d;
  logic [3:0]         sh_cnt_q, sh_cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_run_q, bit_run_d;
  logic               bit_tail_q, bit_tail_d;
  logic               err_q, err_d;

  logic               avail;
  logic               cur_bit;
  logic               fire;
  logic               byte_ready_w;
  logic               accept;
  logic [SYM_W-1:0]   n_dbps;
  logic [LEN_W+2:0]   data_last;

  function automatic logic [SYM_W-1:0] ndbps(input logic [3:0] r);
    case (r)
      4'b1101: ndbps = SYM_W'(24);
      4'b1111: ndbps = SYM_W'(36);
      4'b0101: ndbps = SYM_W'(48);
      4'b0111: ndbps = SYM_W'(72);
      4'b1001: ndbps = SYM_W'(96);
      4'b1011: ndbps = SYM_W'(144);
      4'b0001: ndbps = SYM_W'(192);
      default: ndbps = SYM_W'(216);
    endcase
  endfunction

  assign n_dbps       = ndbps(rate_q);
  assign data_last    = {len_q - LEN_W'(1), 3'b111};
  assign byte_ready_w = ((state_q == S_SERVICE) || (state_q == S_DATA)) &&
                        !hold_full_q && (acc_q < len_q);
  assign accept       = byte_ready_w && byte_valid;
  assign fire         = avail && scr_ready;

  // In DATA the shift register is the bit source; an empty one borrows hold directly.
  always_comb begin
    avail   = 1'b0;
    cur_bit = 1'b0;
    case (state_q)
      S_SERVICE, S_TAIL: avail = 1'b1;
      S_DATA: begin
        avail   = (sh_cnt_q != 4'd0) || hold_full_q;
        cur_bit = (sh_cnt_q != 4'd0) ? sh_q[0] : hold_q[0];
      end
      S_PAD:   avail = (sym_cnt_q != '0);
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    len_d       = len_q;
    acc_d       = acc_q;
    data_cnt_d  = data_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    bit_out_d   = 1'b0;
    bit_run_d   = 1'b0;
    bit_tail_d  = 1'b0;
    err_d       = 1'b0;

    if (fire) begin
      bit_run_d = 1'b1;
      bit_out_d = cur_bit;
      sym_cnt_d = (sym_cnt_q == n_dbps - SYM_W'(1)) ? '0 : sym_cnt_q + SYM_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!rate_in[0] || (length == '0)) begin
            err_d = 1'b1;
          end else begin
            rate_d  = rate_in;
            len_d   = length;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        sym_cnt_d   = '0;
        cnt_d       = 4'd0;
        data_cnt_d  = '0;
        acc_d       = '0;
        hold_full_d = 1'b0;
        sh_cnt_d    = 4'd0;
        state_d     = S_SERVICE;
      end
      S_SERVICE: begin
        if (fire) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          data_cnt_d = data_cnt_q + (LEN_W+3)'(1);
          if (sh_cnt_q == 4'd0) begin
            sh_d        = hold_q >> 1;
            sh_cnt_d    = 4'd7;
            hold_full_d = 1'b0;
          end else if ((sh_cnt_q == 4'd1) && hold_full_q) begin
            sh_d        = hold_q;
            sh_cnt_d    = 4'd8;
            hold_full_d = 1'b0;
          end else begin
            sh_d     = sh_q >> 1;
            sh_cnt_d = sh_cnt_q - 4'd1;
          end
          if (data_cnt_q == data_last) begin
            cnt_d   = 4'd0;
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (fire) begin
          bit_tail_d = 1'b1;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            cnt_d   = 4'd0;
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (sym_cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance needs an empty hold, so it never collides with a hold drain above.
    if (accept) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
      acc_d       = acc_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rate_q      <= 4'd0;
      len_q       <= '0;
      acc_q       <= '0;
      data_cnt_q  <= '0;
      sym_cnt_q   <= '0;
      cnt_q       <= 4'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      sh_q        <= 8'd0;
      sh_cnt_q    <= 4'd0;
      bit_out_q   <= 1'b0;
      bit_run_q   <= 1'b0;
      bit_tail_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      data_cnt_q  <= data_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_run_q   <= bit_run_d;
      bit_tail_q  <= bit_tail_d;
      err_q       <= err_d;
    end
  end

  assign byte_ready = byte_ready_w;
  assign bit_out    = bit_out_q;
  assign bit_run    = bit_run_q;
  assign bit_tail   = bit_tail_q;
  assign tx_request = (state_q == S_REQ);
  assign rate_out   = rate_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_ppdu_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_ppdu_framer
// Purpose : Scoreboard bench for tx_ppdu_framer frame construction.
// Rev     : 1.0
// ============================================================================
module tb_tx_ppdu_framer;

  localparam int LEN_W = 12;
  localparam int SYM_W = 8;
  localparam int LIMIT = 5000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       rate_in;
  logic [LEN_W-1:0] length;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             scr_ready;
  logic             bit_out;
  logic             bit_run;
  logic             bit_tail;
  logic             tx_request;
  logic [3:0]       rate_out;
  logic             busy;
  logic             done;
  logic             err;

  int tests_run = 0;
  int fails     = 0;
  logic [1:0] exp_q[$];

  tx_ppdu_framer #(.LEN_W(LEN_W), .SYM_W(SYM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rate_in(rate_in), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .scr_ready(scr_ready), .bit_out(bit_out), .bit_run(bit_run),
    .bit_tail(bit_tail), .tx_request(tx_request), .rate_out(rate_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int model_ndbps(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 1;
    endcase
  endfunction

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({busy, bit_run, bit_out, bit_tail, tx_request, done, err, byte_ready, rate_out} !== 12'h000) begin
      fails++;
      $display("FAIL %s: outputs busy/run/out/tail/req/done/err/rdy/rate = %b, required all 0", name,
               {busy, bit_run, bit_out, bit_tail, tx_request, done, err, byte_ready, rate_out});
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input int len, input logic [7:0] first_byte,
                           input int scr_mode, input int underrun_at, input int busy_start_at,
                           input int abort_at, output int nbits, output int maxgap);
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [1:0] e;
    int total, n, padn, bi, gap, hold_cnt, nreq;
    bit under_done, finished;
    exp_q.delete();
    bytes.delete();
    nbits = 0; maxgap = 0; gap = 0; bi = 0; hold_cnt = 0; nreq = 0;
    under_done = 1'b0; finished = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = (i == 0) ? first_byte : 8'($urandom_range(0, 255));
      bytes.push_back(b);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(2'b00);
    for (int i = 0; i < len; i++) begin
      b = bytes[i];
      for (int j = 0; j < 8; j++) exp_q.push_back({1'b0, b[j]});
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(2'b10);
    total = 22 + 8 * len;
    n     = model_ndbps(rate);
    padn  = (n - (total % n)) % n;
    for (int i = 0; i < padn; i++) exp_q.push_back(2'b00);
    total = total + padn;

    @(negedge clk);
    start = 1'b1; rate_in = rate; length = len[LEN_W-1:0];
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (tx_request !== 1'b1 || rate_out !== rate) begin
      fails++;
      $display("FAIL tx_request: req=%b rate_out=%b, required req=1 rate_out=%b", tx_request, rate_out, rate);
    end

    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      @(negedge clk);
      if (bit_run) begin
        nbits++;
        if (gap > maxgap) maxgap = gap;
        gap = 0;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_bit: bit %0d tail/bit=%b, required no bit", nbits, {bit_tail, bit_out});
        end else begin
          e = exp_q.pop_front();
          if ({bit_tail, bit_out} !== e) begin
            fails++;
            $display("FAIL bit_%0d: tail/bit=%b, required %b", nbits, {bit_tail, bit_out}, e);
          end
        end
      end else if (nbits > 0) begin
        gap++;
      end
      if (abort_at >= 0 && nbits == abort_at) begin
        #1 rst = 1'b0;
        #1 check_all_zero("abort_reset");
        exp_q.delete();
        byte_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (tx_request) nreq++;

      start = 1'b0;
      if (cyc == busy_start_at) begin
        start = 1'b1; rate_in = 4'b0011; length = LEN_W'(7);
      end
      scr_ready = (scr_mode == 1) ? ((cyc % 5) >= 3) : 1'b1;
      if (hold_cnt > 0) begin
        byte_valid = 1'b0;
        hold_cnt--;
      end else if (bi < len) begin
        if (bi == underrun_at && !under_done && byte_ready) begin
          under_done = 1'b1; hold_cnt = 19; byte_valid = 1'b0;
        end else begin
          byte_valid = 1'b1; byte_in = bytes[bi];
          if (byte_ready) bi++;
        end
      end else begin
        byte_valid = 1'b0;
      end
    end
    start = 1'b0; byte_valid = 1'b0; scr_ready = 1'b1;

    tests_run++;
    if (!finished) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", LIMIT);
    end
    tests_run++;
    if (nbits !== total || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bit_count: %0d bits (%0d unmatched), required %0d", nbits, exp_q.size(), total);
    end
    tests_run++;
    if (nreq != 0) begin
      fails++;
      $display("FAIL extra_request: %0d tx_request cycles mid-frame, required 0", nreq);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || rate_out !== rate) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b rate_out=%b, required 0 0 %b", done, busy, rate_out, rate);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rate_in = 4'd0; length = '0;
    byte_in = 8'd0; byte_valid = 1'b0; scr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    int nb, mg;
    run_frame(4'b1101, 1, 8'hA5, 0, -1, -1, -1, nb, mg);
    tests_run++;
    if (nb != 48) begin
      fails++;
      $display("FAIL basic_total: %0d bits, required 48", nb);
    end
  endtask

  task automatic test_long();
    int nb, mg;
    run_frame(4'b0011, 100, 8'h3C, 0, -1, -1, -1, nb, mg);
    tests_run++;
    if (nb != 864) begin
      fails++;
      $display("FAIL long_total: %0d bits, required 864", nb);
    end
  endtask

  task automatic test_stall();
    int nb, mg;
    run_frame(4'b1001, 10, 8'h81, 1, -1, -1, -1, nb, mg);
    tests_run++;
    if (nb != 192) begin
      fails++;
      $display("FAIL stall_total: %0d bits, required 192", nb);
    end
  endtask

  task automatic test_underrun();
    int nb, mg;
    run_frame(4'b0101, 4, 8'hF0, 0, 2, -1, -1, nb, mg);
    tests_run++;
    if (nb != 96) begin
      fails++;
      $display("FAIL underrun_total: %0d bits, required 96", nb);
    end
    tests_run++;
    if (mg < 10) begin
      fails++;
      $display("FAIL underrun_gap: longest bit_run gap %0d, required at least 10", mg);
    end
  endtask

  task automatic test_errors();
    @(negedge clk);
    start = 1'b1; rate_in = 4'b0100; length = LEN_W'(5);
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (err !== 1'b1 || tx_request !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_bad_rate: err=%b req=%b busy=%b, required 1 0 0", err, tx_request, busy);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_len: err=%b busy=%b, required 0 0", err, busy);
    end
    start = 1'b1; rate_in = 4'b1101; length = '0;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (err !== 1'b1 || tx_request !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_zero_len: err=%b req=%b busy=%b, required 1 0 0", err, tx_request, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    int nb, mg;
    run_frame(4'b0111, 3, 8'h5A, 0, -1, 30, -1, nb, mg);
    tests_run++;
    if (nb != 72) begin
      fails++;
      $display("FAIL busy_start_total: %0d bits, required 72", nb);
    end
  endtask

  task automatic test_abort();
    int nb, mg;
    run_frame(4'b1101, 50, 8'h11, 0, -1, -1, 30, nb, mg);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || bit_run !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: done=%b busy=%b run=%b, required 0 0 0", done, busy, bit_run);
    end
    run_frame(4'b1101, 1, 8'hC3, 0, -1, -1, -1, nb, mg);
    tests_run++;
    if (nb != 48) begin
      fails++;
      $display("FAIL abort_recover: %0d bits, required 48", nb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long();
    test_stall();
    test_underrun();
    test_errors();
    test_busy_start();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_ppdu_framer.md
Name: tx_ppdu_framer

Overview:
- Upstream feeder of the 802.11a TX chain. Accepts a PSDU byte stream and drives the serial bit input of the transmit top: in, run, rate, tx_request.
- Builds the DATA field in this order: 16 SERVICE bits (all zero), PSDU bits LSB first, 6 tail bits, then zero pad bits up to a whole number of OFDM symbols for the selected rate.
- Issues the tx_request/rate pulse that latches the rate into the TX chain.

Parameters:
- LEN_W, 12, width of the PSDU length in bytes (valid length 1..4095).
- SYM_W, 8, width of the per-symbol bit counter (must hold 215).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to frame a PSDU; sampled only in IDLE
- rate_in  input  4  RATE code: 1101, 1111, 0101, 0111, 1001, 1011, 0001, 0011
- length  input  LEN_W  PSDU length in bytes, sampled with start
- byte_in  input  8  PSDU byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  framer can take a byte this cycle
- scr_ready  input  1  downstream scrambler ready
- bit_out  output  1  serial bit, connects to TX in
- bit_run  output  1  bit_out valid, connects to TX run
- bit_tail  output  1  bit_out is a tail bit; downstream zeroes it after scrambling
- tx_request  output  1  one-cycle pulse, connects to TX tx_request
- rate_out  output  4  latched rate, connects to TX rate
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last pad bit
- err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: all outputs 0, rate_out 0, state IDLE, all counters and buffers cleared.
- Reset asserted mid-frame aborts immediately with no done pulse. The next start after reset release is handled normally.
- N_DBPS per rate code:
  - 1101 → 24
  - 1111 → 36
  - 0101 → 48
  - 0111 → 72
  - 1001 → 96
  - 1011 → 144
  - 0001 → 192
  - 0011 → 216
- State IDLE:
  - start with rate_in[0]==0 or length==0 → err=1 for the next cycle, remain in IDLE.
  - start with a valid rate and length → latch rate and length, go to REQ.
  - start in any state other than IDLE is ignored.
- State REQ (exactly one cycle): tx_request=1 and rate_out=latched rate in this cycle. Go to SERVICE. rate_out holds until the next accepted start.
- Bit handshake:
  - bit_out, bit_run and bit_tail are registered.
  - At each clock edge in an emitting state: if scr_ready==1 and a bit is available, the next cycle has bit_run=1 with that bit. Otherwise the next cycle has bit_run=0 and no counter advances.
  - One bit per bit_run cycle; no bit is ever lost or duplicated across a stall.
- Symbol counter sym_cnt (SYM_W bits):
  - Increments on every emitted bit.
  - Wraps to 0 after reaching N_DBPS−1.
  - Cleared in REQ.
- State SERVICE: emit 16 zeros, then go to DATA.
- State DATA: emit length×8 bits, each byte LSB first.
- Byte buffering:
  - A one-byte holding register plus an 8-bit shift register.
  - byte_ready=1 in SERVICE/DATA when the holding register is empty and fewer than length bytes have been accepted.
  - The shift register reloads from the holding register when its last bit is emitted.
  - If both are empty: no bit is available (stall), no error.
  - Extra bytes beyond length are never accepted (byte_ready=0).
- State TAIL: emit 6 zeros with bit_tail=1, then go to PAD.
- State PAD:
  - Emit zeros while sym_cnt≠0 after the tail.
  - Pad count = N_SYM×N_DBPS − (22 + 8×length).
  - With the rates above this count is never 0. The design still must go straight to DONE if sym_cnt==0 on entry.
- State DONE: done=1 for one cycle, then IDLE. Total bits emitted are always a multiple of N_DBPS.

Test Plan:
- Rate 1101, length 1, byte 0xA5, scr_ready=1 → tx_request pulse with rate_out=1101; 48 bits: 16 zeros, 1,0,1,0,0,1,0,1, 6 tail zeros with bit_tail=1, 18 pad zeros; done pulse; busy low after.
- Rate 0011, length 100 → exactly 864 bit_run cycles (822 framed plus 42 pad), bit_tail high on bits 817..822 (1-based), one done pulse.
- Rate 1001, length 10, scr_ready toggling in a 3-low/2-high pattern → bit sequence identical to the no-stall run, 192 bits, no gaps while scr_ready is high.
- Rate 0101, length 4, byte_valid held low for 20 cycles mid-DATA → bit_run low during the underrun, resumes with the correct next bit, total 96 bits.
- start with rate_in=0100 and with length=0 → err pulse each time, no tx_request, busy stays 0; start while busy → ignored.
- Reset asserted during DATA of a length-50 frame → all outputs 0 in the same cycle; a subsequent length-1 rate-1101 frame completes with 48 bits.
